// File: rtl/regfile_sb_if.sv
// regfile_sb_if: bus bundle for the regfile_sb register file.
//   master : drives write/link/mark/read-address requests, receives read data, busy, ready
//   slave  : the register file side
// Signals:
//   regwrite/write_reg/write_data  general write port
//   jump_link/link_data            link write to the link register
//   read_reg_1/2 -> read_data_1/2  combinational read ports
//   mark_valid/mark_reg            set busy bit of a register with an outstanding producer
//   busy_1/busy_2                  busy bit of read_reg_1/read_reg_2
//   ready                          clear sweep finished
interface regfile_sb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              regwrite;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              jump_link;
  logic [DATA_W-1:0] link_data;
  logic [ADDR_W-1:0] read_reg_1;
  logic [ADDR_W-1:0] read_reg_2;
  logic [DATA_W-1:0] read_data_1;
  logic [DATA_W-1:0] read_data_2;
  logic              mark_valid;
  logic [ADDR_W-1:0] mark_reg;
  logic              busy_1;
  logic              busy_2;
  logic              ready;

  modport master (
    output regwrite, write_reg, write_data, jump_link, link_data,
    output read_reg_1, read_reg_2, mark_valid, mark_reg,
    input  read_data_1, read_data_2, busy_1, busy_2, ready
  );

  modport slave (
    input  regwrite, write_reg, write_data, jump_link, link_data,
    input  read_reg_1, read_reg_2, mark_valid, mark_reg,
    output read_data_1, read_data_2, busy_1, busy_2, ready
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: register file with two combinational read ports, one write port, a dedicated
// link write port, a post-reset clear sweep, hardwired zero register and a per-register busy
// scoreboard for outstanding loads.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset; restarts the clear sweep
//   bus      regfile_sb_if.slave (write/link/mark requests, reads, busy, ready)
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to the reads.
module regfile_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned LINK_REG = 31
) (
  input logic          i_clk,
  input logic          i_rst_n,
  regfile_sb_if.slave  bus
);
  localparam int unsigned       DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LinkAddr = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(DEPTH - 1);

  typedef enum logic {StClear, StRun} state_e;

  state_e            r_state, w_state_d;
  logic [ADDR_W-1:0] r_idx, w_idx_d;
  logic [DEPTH-1:0]  r_busy, w_busy_d;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_ready, w_wr_en, w_link_en, w_mark_en;

  // State, sweep index and busy bits reset asynchronously; storage does not.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StClear;
      r_idx   <= ADDR_W'(1);
      r_busy  <= '0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_busy  <= w_busy_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    unique case (r_state)
      StClear: begin
        w_idx_d = r_idx + ADDR_W'(1);
        if (r_idx == LastIdx) w_state_d = StRun;
      end
      StRun:   w_state_d = StRun;
      default: w_state_d = StClear;
    endcase
  end

  assign w_ready   = (r_state == StRun);
  assign w_link_en = w_ready && bus.jump_link && (LinkAddr != '0);
  // The link write wins a collision on the link register, so the general write is dropped.
  assign w_wr_en   = w_ready && bus.regwrite && (bus.write_reg != '0) &&
                     !(w_link_en && (bus.write_reg == LinkAddr));
  assign w_mark_en = w_ready && bus.mark_valid && (bus.mark_reg != '0);

  // Commits clear busy; a mark on the same edge is applied last so it wins.
  always_comb begin
    w_busy_d = r_busy;
    if (w_wr_en)   w_busy_d[bus.write_reg] = 1'b0;
    if (w_link_en) w_busy_d[LinkAddr]      = 1'b0;
    if (w_mark_en) w_busy_d[bus.mark_reg]  = 1'b1;
    w_busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (r_state == StClear) begin
      r_mem[r_idx] <= '0;
    end else begin
      if (w_wr_en)   r_mem[bus.write_reg] <= bus.write_data;
      if (w_link_en) r_mem[LinkAddr]      <= bus.link_data;
    end
  end

  logic [DATA_W-1:0] w_rd1, w_rd2;
  logic              w_bsy1, w_bsy2;

  always_comb begin
    w_rd1  = '0;
    w_rd2  = '0;
    w_bsy1 = 1'b0;
    w_bsy2 = 1'b0;
    if (w_ready && (bus.read_reg_1 != '0)) begin
      w_rd1  = r_mem[bus.read_reg_1];
      w_bsy1 = r_busy[bus.read_reg_1];
`ifdef REGFILE_BYPASS_EN
      if (w_link_en && (bus.read_reg_1 == LinkAddr)) w_rd1 = bus.link_data;
      else if (w_wr_en && (bus.read_reg_1 == bus.write_reg)) w_rd1 = bus.write_data;
      if (((w_link_en && (bus.read_reg_1 == LinkAddr)) ||
           (w_wr_en && (bus.read_reg_1 == bus.write_reg))) &&
          !(w_mark_en && (bus.mark_reg == bus.read_reg_1))) w_bsy1 = 1'b0;
`endif
    end
    if (w_ready && (bus.read_reg_2 != '0)) begin
      w_rd2  = r_mem[bus.read_reg_2];
      w_bsy2 = r_busy[bus.read_reg_2];
`ifdef REGFILE_BYPASS_EN
      if (w_link_en && (bus.read_reg_2 == LinkAddr)) w_rd2 = bus.link_data;
      else if (w_wr_en && (bus.read_reg_2 == bus.write_reg)) w_rd2 = bus.write_data;
      if (((w_link_en && (bus.read_reg_2 == LinkAddr)) ||
           (w_wr_en && (bus.read_reg_2 == bus.write_reg))) &&
          !(w_mark_en && (bus.mark_reg == bus.read_reg_2))) w_bsy2 = 1'b0;
`endif
    end
  end

  assign bus.read_data_1 = w_rd1;
  assign bus.read_data_2 = w_rd2;
  assign bus.busy_1      = w_bsy1;
  assign bus.busy_2      = w_bsy2;
  assign bus.ready       = w_ready;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: self-checking bench for regfile_sb. Expected output values are pushed to a
// scoreboard queue when stimulus is driven and popped/compared when outputs are sampled.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic i_rst_n;

  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .LINK_REG(31)) dut (
    .i_clk   (clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  localparam int SelRd1 = 0, SelRd2 = 1, SelBusy1 = 2, SelBusy2 = 3, SelReady = 4;

  typedef struct {
    int          sel;
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk;
  int   n_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input int sel, input string tag, input logic [31:0] val);
    exp_t e;
    e.sel = sel;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        SelRd1:   check_eq(e.tag, bus.read_data_1, e.val);
        SelRd2:   check_eq(e.tag, bus.read_data_2, e.val);
        SelBusy1: check_eq(e.tag, {31'd0, bus.busy_1}, e.val);
        SelBusy2: check_eq(e.tag, {31'd0, bus.busy_2}, e.val);
        default:  check_eq(e.tag, {31'd0, bus.ready}, e.val);
      endcase
    end
  endtask

  task automatic idle_in();
    bus.regwrite   = 1'b0;
    bus.write_reg  = '0;
    bus.write_data = '0;
    bus.jump_link  = 1'b0;
    bus.link_data  = '0;
    bus.mark_valid = 1'b0;
    bus.mark_reg   = '0;
  endtask

  // Releases reset and counts falling edges until ready, with writes/marks held active to
  // show they are ignored during the sweep.
  task automatic sweep();
    int n;
    n = 0;
    @(negedge clk);
    i_rst_n        = 1'b1;
    bus.regwrite   = 1'b1;
    bus.write_reg  = 5'd6;
    bus.write_data = 32'h0000_0066;
    bus.jump_link  = 1'b1;
    bus.link_data  = 32'h0000_0077;
    bus.mark_valid = 1'b1;
    bus.mark_reg   = 5'd6;
    bus.read_reg_1 = 5'd5;
    bus.read_reg_2 = 5'd6;
    while (n < 100) begin
      @(negedge clk);
      n++;
      push(SelRd1, "sweep_rd5", 32'd0);
      push(SelBusy1, "sweep_busy5", 32'd0);
      drain();
      if (bus.ready) break;
    end
    idle_in();
    check_eq("sweep_edges", n, 32'd31);
    bus.read_reg_1 = 5'd6;
    bus.read_reg_2 = 5'd31;
    #2;
    push(SelRd1, "sweep_rd6", 32'd0);
    push(SelRd2, "sweep_rd31", 32'd0);
    push(SelBusy1, "sweep_busy6", 32'd0);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk   = 0;
    n_err   = 0;
    i_rst_n = 1'b0;
    idle_in();
    bus.read_reg_1 = 5'd5;
    bus.read_reg_2 = 5'd6;
    #3;
    push(SelReady, "rst_ready", 32'd0);
    push(SelRd1, "rst_rd1", 32'd0);
    push(SelRd2, "rst_rd2", 32'd0);
    push(SelBusy1, "rst_busy1", 32'd0);
    push(SelBusy2, "rst_busy2", 32'd0);
    drain();

    sweep();

    // Preload register 5 for the later reset test.
    @(negedge clk);
    bus.regwrite = 1'b1; bus.write_reg = 5'd5; bus.write_data = 32'd15;
    bus.read_reg_1 = 5'd5;
    @(negedge clk);
    idle_in();
    #2;
    push(SelRd1, "wr5_rd", 32'd15);
    drain();

    // Zero register: writes and marks dropped.
    @(negedge clk);
    bus.regwrite = 1'b1; bus.write_reg = 5'd0; bus.write_data = 32'hDEAD_BEEF;
    bus.mark_valid = 1'b1; bus.mark_reg = 5'd0;
    bus.read_reg_1 = 5'd0;
    @(negedge clk);
    idle_in();
    #2;
    push(SelRd1, "zero_rd", 32'd0);
    push(SelBusy1, "zero_busy", 32'd0);
    drain();

    // Link collision: jump_link wins on register 31.
    @(negedge clk);
    bus.regwrite = 1'b1; bus.write_reg = 5'd31; bus.write_data = 32'h0000_1111;
    bus.jump_link = 1'b1; bus.link_data = 32'h0000_2222;
    bus.read_reg_1 = 5'd31;
    @(negedge clk);
    idle_in();
    #2;
    push(SelRd1, "link_collide", 32'h0000_2222);
    drain();

    // Non-colliding: both writes stored.
    @(negedge clk);
    bus.regwrite = 1'b1; bus.write_reg = 5'd7; bus.write_data = 32'h0000_7777;
    bus.jump_link = 1'b1; bus.link_data = 32'h0000_3333;
    bus.read_reg_1 = 5'd7;
    bus.read_reg_2 = 5'd31;
    @(negedge clk);
    idle_in();
    #2;
    push(SelRd1, "both_rd7", 32'h0000_7777);
    push(SelRd2, "both_rd31", 32'h0000_3333);
    drain();

    // Scoreboard: mark then clear by write.
    @(negedge clk);
    bus.mark_valid = 1'b1; bus.mark_reg = 5'd9;
    bus.read_reg_1 = 5'd9;
    bus.read_reg_2 = 5'd8;
    @(negedge clk);
    idle_in();
    #2;
    push(SelBusy1, "mark9_busy", 32'd1);
    push(SelBusy2, "mark9_busy8", 32'd0);
    drain();
    @(negedge clk);
    bus.regwrite = 1'b1; bus.write_reg = 5'd9; bus.write_data = 32'h0000_0011;
    #2;
`ifdef REGFILE_BYPASS_EN
    push(SelBusy1, "wr9_busy_same", 32'd0);
`else
    push(SelBusy1, "wr9_busy_same", 32'd1);
`endif
    drain();
    @(negedge clk);
    idle_in();
    #2;
    push(SelBusy1, "wr9_busy_after", 32'd0);
    push(SelRd1, "wr9_rd", 32'h0000_0011);
    drain();

    // Mark and write on the same edge: mark wins, value stored.
    @(negedge clk);
    bus.regwrite = 1'b1; bus.write_reg = 5'd9; bus.write_data = 32'h0000_00A5;
    bus.mark_valid = 1'b1; bus.mark_reg = 5'd9;
    @(negedge clk);
    idle_in();
    #2;
    push(SelBusy1, "markwr9_busy", 32'd1);
    push(SelRd1, "markwr9_rd", 32'h0000_00A5);
    drain();

    // Same-cycle read of a register being written.
    @(negedge clk);
    bus.regwrite = 1'b1; bus.write_reg = 5'd3; bus.write_data = 32'h0000_1234;
    bus.jump_link = 1'b1; bus.link_data = 32'h0000_4444;
    bus.read_reg_1 = 5'd3;
    bus.read_reg_2 = 5'd31;
    #2;
`ifdef REGFILE_BYPASS_EN
    push(SelRd1, "byp_rd3", 32'h0000_1234);
    push(SelRd2, "byp_rd31", 32'h0000_4444);
`else
    push(SelRd1, "byp_rd3", 32'd0);
    push(SelRd2, "byp_rd31", 32'h0000_3333);
`endif
    drain();
    @(negedge clk);
    idle_in();
    #2;
    push(SelRd1, "byp_rd3_next", 32'h0000_1234);
    push(SelRd2, "byp_rd31_next", 32'h0000_4444);
    drain();

    // Busy bits cleared asynchronously by reset.
    @(negedge clk);
    bus.mark_valid = 1'b1; bus.mark_reg = 5'd12;
    bus.read_reg_1 = 5'd12;
    @(negedge clk);
    idle_in();
    #2;
    push(SelBusy1, "mark12_busy", 32'd1);
    drain();
    i_rst_n = 1'b0;
    #1;
    push(SelReady, "async_rst_ready", 32'd0);
    push(SelBusy1, "async_rst_busy", 32'd0);
    push(SelRd1, "async_rst_rd", 32'd0);
    drain();

    // Reset mid-sweep, then a full sweep must follow.
    @(negedge clk);
    i_rst_n = 1'b1;
    repeat (10) @(negedge clk);
    push(SelReady, "midsweep_ready", 32'd0);
    drain();
    i_rst_n = 1'b0;
    #1;
    push(SelReady, "midsweep_rst_ready", 32'd0);
    drain();
    sweep();
    bus.read_reg_1 = 5'd3;
    bus.read_reg_2 = 5'd9;
    #1;
    push(SelRd1, "resweep_rd3", 32'd0);
    push(SelRd2, "resweep_rd9", 32'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
